resp_return_router: RTL and testbench

Per-slave-port response return path for the AXI4 crossbar. It records, in grant order, which master won each request arbitration for this slave. It then steers the slave's response beats (B or R channel) back to that master with full valid/ready handshaking, releasing each entry on the last beat. It is the counterpart of the request-side priority select logic: that logic decides master→slave, this block returns slave→master. One instance sits on every slave port, on each of the B and R channels.

---
 rtl/crossbar_pkg.sv | 25 ++
 rtl/resp_return_router_onehot_to_index.sv | 29 ++
 rtl/resp_return_router.sv | 145 ++++++++++++++
 tb/tb_resp_return_router.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// ---------------------------------------------------------------------------
// crossbar_pkg
// Shared definitions for the AXI4 crossbar request and response paths.
//   MST_NUM_DEFAULT : default number of master ports
//   mst_idx_t       : binary master index for the default master count
//   idx_width()     : bits needed to index n items (never less than 1)
//   cnt_width()     : bits needed to count 0..depth inclusive
// ---------------------------------------------------------------------------
package crossbar_pkg;

  localparam int MST_NUM_DEFAULT = 8;

  typedef logic [$clog2(MST_NUM_DEFAULT)-1:0] mst_idx_t;

  // A single-item index still needs one bit so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A counter for a table of 'depth' entries must also represent the full value.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/resp_return_router_onehot_to_index.sv
// ---------------------------------------------------------------------------
// onehot_to_index
// Parameterised one-hot to binary converter with lowest-bit priority.
// Shared with the request-side select logic.
//   onehot : N-bit input vector, expected one-hot
//   index  : W-bit binary index of the lowest set bit; 0 when no bit is set
// ---------------------------------------------------------------------------
module onehot_to_index
  import crossbar_pkg::*;
#(
  parameter int N = MST_NUM_DEFAULT,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] index
);

  // Scanning from the top down lets the lowest set bit overwrite any higher
  // one, so an illegal multi-hot input still resolves deterministically.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        index = W'(i);
      end
    end
  end

endmodule

// File: rtl/resp_return_router.sv
// ---------------------------------------------------------------------------
// resp_return_router
// Response return path for one slave port of the AXI4 crossbar (B or R).
// Records the winning master of every request granted to this slave, in
// grant order, and steers the slave's response beats back to that master.
// An entry is released on the beat that carries s_last.
//
// Ports:
//   ACLK, ARESETn           : clock, synchronous active-low reset
//   grant_valid, grant_sel  : request handshake done this cycle, one-hot winner
//   grant_ready             : table has room (registered count only)
//   s_valid/s_payload/s_last/s_ready : slave-side response channel
//   m_valid/m_payload/m_last/m_ready : master-side response channels
//   err_unexpected          : sticky, response seen with nothing outstanding
//
// Build option: RESP_ROUTER_ERR_EN
//   defined   - empty table accepts and drops beats, err_unexpected exists
//   undefined - empty table stalls the slave (s_ready=0), no error port
// ---------------------------------------------------------------------------
module resp_return_router
  import crossbar_pkg::*;
#(
  parameter int MST_NUM       = MST_NUM_DEFAULT,
  parameter int DEPTH         = 4,
  parameter int PAYLOAD_WIDTH = 2
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     grant_valid,
  input  logic [MST_NUM-1:0]       grant_sel,
  output logic                     grant_ready,
  input  logic                     s_valid,
  input  logic [PAYLOAD_WIDTH-1:0] s_payload,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [MST_NUM-1:0]       m_valid,
  output logic [PAYLOAD_WIDTH-1:0] m_payload,
  output logic                     m_last,
  input  logic [MST_NUM-1:0]       m_ready
`ifdef RESP_ROUTER_ERR_EN
  ,
  output logic                     err_unexpected
`endif
);

  localparam int IDX_W = idx_width(MST_NUM);
  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifdef RESP_ROUTER_ERR_EN
  localparam logic EMPTY_READY = 1'b1;
`else
  localparam logic EMPTY_READY = 1'b0;
`endif

  logic [IDX_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] head;
  logic             not_empty;
  logic             push;
  logic             pop;

  onehot_to_index #(
    .N(MST_NUM),
    .W(IDX_W)
  ) u_grant_idx (
    .onehot(grant_sel),
    .index (grant_idx)
  );

  assign not_empty   = (count != '0);
  // Derived from the registered count only, so a full table refuses a push
  // even in a cycle where the head is being popped.
  assign grant_ready = (count != FULL_CNT);
  assign head        = entries[rd_ptr];
  assign push        = grant_valid & grant_ready;
  // Only the last beat of a response releases its entry; a beat accepted
  // while the table is empty has no entry to release.
  assign pop         = s_valid & s_ready & s_last & not_empty;

  // Entry storage needs no reset: the count alone decides which entries are
  // live, so stale contents are never observed.
  always_ff @(posedge ACLK) begin
    if (push) begin
      entries[wr_ptr] <= grant_idx;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two so the pointers wrap
  // naturally. A simultaneous push and pop moves both pointers and leaves
  // the count unchanged.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Zero-latency steering: the head entry selects which master sees the
  // slave's valid and whose ready goes back to the slave. A fresh push is
  // only visible as head from the following cycle.
  always_comb begin
    m_valid = '0;
    s_ready = EMPTY_READY;
    if (not_empty) begin
      m_valid[head] = s_valid;
      s_ready       = m_ready[head];
    end
  end

  assign m_payload = s_payload;
  // Gated by occupancy so a B channel that ties s_last high does not show a
  // last flag to the masters while nothing is outstanding.
  assign m_last    = s_last & not_empty;

`ifdef RESP_ROUTER_ERR_EN
  // Sticky flag: any response offered while nothing is outstanding is a
  // protocol violation by the slave; it holds until the crossbar resets.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      err_unexpected <= 1'b0;
    end else if (s_valid && !not_empty) begin
      err_unexpected <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_resp_return_router.sv
// ---------------------------------------------------------------------------
// tb_resp_return_router
// Self-checking bench for resp_return_router (MST_NUM=8, DEPTH=4, 2-bit
// payload). Grants push expected beats into a scoreboard queue; a monitor
// pops and compares on every master-side handshake and also checks the
// per-cycle outputs against a queue-based model of outstanding grants.
// Honours RESP_ROUTER_ERR_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_resp_return_router;

  localparam int MST_NUM = 8;
  localparam int DEPTH   = 4;
  localparam int PW      = 2;

`ifdef RESP_ROUTER_ERR_EN
  localparam logic EMPTY_RDY = 1'b1;
`else
  localparam logic EMPTY_RDY = 1'b0;
`endif

  typedef struct {
    int            m;
    logic [PW-1:0] p;
    bit            last;
  } beat_t;

  logic               ACLK = 1'b0;
  logic               ARESETn = 1'b0;
  logic               grant_valid = 1'b0;
  logic [MST_NUM-1:0] grant_sel = '0;
  logic               grant_ready;
  logic               s_valid = 1'b0;
  logic [PW-1:0]      s_payload = '0;
  logic               s_last = 1'b0;
  logic               s_ready;
  logic [MST_NUM-1:0] m_valid;
  logic [PW-1:0]      m_payload;
  logic               m_last;
  logic [MST_NUM-1:0] m_ready = '0;
`ifdef RESP_ROUTER_ERR_EN
  logic               err_unexpected;
`endif

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t resp_todo[$];
  int    tbl[$];
  bit    err_exp = 1'b0;
  bit    mon_en = 1'b0;
  bit    resp_en = 1'b0;
  bit    holding = 1'b0;
  int    rdy_mode = 0;
  int    cyc = 0;

  // Monitor scratch state
  bit                 mon_ne;
  int                 mon_head;
  logic [MST_NUM-1:0] mon_mv;
  logic               mon_sr;
  logic               mon_ml;
  bit                 mon_push;
  bit                 mon_pop;
  int                 mon_idx;
  beat_t              mon_bt;

  always #5 ACLK = ~ACLK;

  resp_return_router #(
    .MST_NUM      (MST_NUM),
    .DEPTH        (DEPTH),
    .PAYLOAD_WIDTH(PW)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .grant_valid(grant_valid),
    .grant_sel  (grant_sel),
    .grant_ready(grant_ready),
    .s_valid    (s_valid),
    .s_payload  (s_payload),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_payload  (m_payload),
    .m_last     (m_last),
    .m_ready    (m_ready)
`ifdef RESP_ROUTER_ERR_EN
    ,
    .err_unexpected(err_unexpected)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic int lowestBit(input logic [MST_NUM-1:0] v);
    for (int i = 0; i < MST_NUM; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Offer a grant for master m carrying 'beats' response beats; holds it
  // until the router takes it, then records the expected beats.
  task automatic applyStimulus(input int m, input int beats);
    beat_t bt;
    int    waited;
    bit    done;
    waited = 0;
    done   = 1'b0;
    @(negedge ACLK);
    grant_valid = 1'b1;
    grant_sel   = MST_NUM'(1 << m);
    while (!done) begin
      #1;
      if (grant_ready === 1'b1) begin
        for (int b = 0; b < beats; b++) begin
          bt.m    = m;
          bt.p    = PW'($urandom);
          bt.last = (b == beats - 1);
          exp_q.push_back(bt);
          resp_todo.push_back(bt);
        end
        done = 1'b1;
      end else if (waited >= 200) begin
        reportTimeout("grant_accept");
        done = 1'b1;
      end else begin
        waited++;
        @(negedge ACLK);
      end
    end
  endtask

  task automatic grantIdle();
    @(negedge ACLK);
    grant_valid = 1'b0;
    grant_sel   = '0;
  endtask

  // Offer a single-beat response 'hold' cycles before its grant exists,
  // then grant it while the beat is still offered.
  task automatic unexpectedBeat(input int m, input int hold);
    beat_t bt;
    bt.m    = m;
    bt.p    = PW'($urandom);
    bt.last = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      s_valid = 1'b1; s_payload = bt.p; s_last = 1'b1;
    end
    @(negedge ACLK);
    s_valid = 1'b1; s_payload = bt.p; s_last = 1'b1;
    grant_valid = 1'b1;
    grant_sel   = MST_NUM'(1 << m);
    exp_q.push_back(bt);
    @(negedge ACLK);
    grant_valid = 1'b0;
    grant_sel   = '0;
    @(negedge ACLK);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || resp_todo.size() != 0 || holding) && w < 2000) begin
      @(negedge ACLK);
      w++;
    end
    if (w >= 2000) reportTimeout("drain");
    repeat (2) @(negedge ACLK);
  endtask

  // Slave model and master ready generator
  initial begin
    forever begin
      @(negedge ACLK);
      cyc++;
      case (rdy_mode)
        1:       m_ready = MST_NUM'($urandom);
        2:       m_ready = (cyc % 2 == 1) ? 8'hFB : 8'hFF;
        default: m_ready = '1;
      endcase
      if (!holding && resp_en) begin
        if (resp_todo.size() > 0 && $urandom_range(0, 3) != 0) begin
          s_valid   = 1'b1;
          s_payload = resp_todo[0].p;
          s_last    = resp_todo[0].last;
          holding   = 1'b1;
        end else begin
          s_valid = 1'b0;
          s_last  = 1'b0;
        end
      end
      if (holding) begin
        #1;
        if (s_ready === 1'b1) begin
          void'(resp_todo.pop_front());
          holding = 1'b0;
        end
      end
    end
  end

  // Monitor: per-cycle model check plus scoreboard pop on master handshake
  initial begin
    forever begin
      @(negedge ACLK);
      #2;
      if (mon_en) begin
        mon_ne   = (tbl.size() != 0);
        mon_head = mon_ne ? tbl[0] : 0;
        mon_mv   = '0;
        if (mon_ne && s_valid) mon_mv[mon_head] = 1'b1;
        mon_sr = mon_ne ? m_ready[mon_head] : EMPTY_RDY;
        mon_ml = mon_ne ? s_last : 1'b0;
        checkOutput("grant_ready", 32'(grant_ready), 32'(tbl.size() != DEPTH));
        checkOutput("m_valid", 32'(m_valid), 32'(mon_mv));
        checkOutput("s_ready", 32'(s_ready), 32'(mon_sr));
        checkOutput("m_last", 32'(m_last), 32'(mon_ml));
        checkOutput("m_payload", 32'(m_payload), 32'(s_payload));
`ifdef RESP_ROUTER_ERR_EN
        checkOutput("err_unexpected", 32'(err_unexpected), 32'(err_exp));
`endif
        if ((m_valid & m_ready) != '0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_unexpected: m_valid=0x%0h with empty scoreboard at %0t", m_valid, $time);
          end else begin
            mon_bt = exp_q.pop_front();
            checkOutput("beat_master", 32'(m_valid), 32'(1 << mon_bt.m));
            checkOutput("beat_payload", 32'(m_payload), 32'(mon_bt.p));
            checkOutput("beat_last", 32'(m_last), 32'(mon_bt.last));
          end
        end
        // Advance the model to what the upcoming rising edge commits
        mon_push = grant_valid && (tbl.size() < DEPTH);
        mon_idx  = lowestBit(grant_sel);
        mon_pop  = s_valid && mon_sr && s_last && mon_ne;
        if (s_valid && !mon_ne) err_exp = 1'b1;
        if (mon_pop) void'(tbl.pop_front());
        if (mon_push) tbl.push_back(mon_idx);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting resp_return_router bench");
    // Reset held for two cycles with idle inputs
    repeat (2) @(negedge ACLK);
    checkOutput("reset_grant_ready", 32'(grant_ready), 32'd1);
    checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_s_ready", 32'(s_ready), 32'(EMPTY_RDY));
    checkOutput("reset_m_last", 32'(m_last), 32'd0);
`ifdef RESP_ROUTER_ERR_EN
    checkOutput("reset_err", 32'(err_unexpected), 32'd0);
`endif
    ARESETn = 1'b1;
    mon_en  = 1'b1;

    // In-order return for masters 3, 5, 0
    rdy_mode = 0;
    resp_en  = 1'b1;
    applyStimulus(3, 1);
    applyStimulus(5, 1);
    applyStimulus(0, 1);
    grantIdle();
    drain();

    // Four-beat burst to master 2 with its ready dropping every other cycle
    rdy_mode = 2;
    applyStimulus(2, 4);
    grantIdle();
    drain();

    // Fill the table, hold a fifth grant against it, then release
    rdy_mode = 0;
    resp_en  = 1'b0;
    applyStimulus(1, 1);
    applyStimulus(2, 2);
    applyStimulus(3, 1);
    applyStimulus(4, 1);
    fork
      begin
        repeat (3) @(negedge ACLK);
        resp_en = 1'b1;
      end
    join_none
    applyStimulus(5, 1);
    applyStimulus(6, 2);
    grantIdle();
    drain();

    // Response offered in the same cycle as its grant, then one offered early
    resp_en = 1'b0;
    unexpectedBeat(1, 0);
    unexpectedBeat(4, 3);
    repeat (2) @(negedge ACLK);

    // Randomised traffic with random master back-pressure
    resp_en  = 1'b1;
    rdy_mode = 1;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) grantIdle();
      else applyStimulus($urandom_range(0, MST_NUM - 1), $urandom_range(1, 4));
    end
    grantIdle();
    drain();

    checkOutput("end_grant_ready", 32'(grant_ready), 32'd1);
    checkOutput("end_m_valid", 32'(m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
